// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with single-edge ops and a multi-cycle shift FSM
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             rin,
  input  logic             lin,
  input  logic [WIDTH-1:0] d,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             sout_r,
  output logic             sout_l
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(WIDTH);
  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] amt_c;
  logic             fill;
  logic             dir;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] run_q;
  always_comb begin
    amt_c  = amt > MAX_AMT ? MAX_AMT : amt;
    next_q = mode == 3'd1 ? {q[WIDTH-2:0], rin} :
             mode == 3'd2 ? {lin, q[WIDTH-1:1]} :
             mode == 3'd3 ? d :
             mode == 3'd4 ? {q[WIDTH-2:0], q[WIDTH-1]} :
             mode == 3'd5 ? {q[0], q[WIDTH-1:1]} : q;
    // dir=1 is a left (toward LSB) multi-shift, matching mode[0] at launch
    run_q  = dir ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      q     <= '0;
      state <= IDLE;
      cnt   <= '0;
      fill  <= 1'b0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        q   <= run_q;
        cnt <= cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end else if (en) begin
        if (mode[2:1] == 2'b11) begin
          cnt  <= amt_c;
          fill <= mode[0] ? lin : rin;
          dir  <= mode[0];
          if (amt_c != '0) state <= RUN;
          else done <= 1'b1;
        end else begin
          q <= next_q;
        end
      end
    end
  end
  assign busy   = state == RUN;
  assign sout_r = q[WIDTH-1];
  assign sout_l = q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: arithmetic reference model with per-cycle compare plus directed literal checks
module tb_univ_shift_reg;
  localparam int W = 8;
  localparam int AW = 4;
  localparam int M = 1 << W;
  localparam int HALF = M / 2;
  logic          clk, clr, en, rin, lin;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [AW-1:0] amt;
  logic [W-1:0]  q;
  logic          busy, done, sout_r, sout_l;
  int n_chk = 0;
  int n_err = 0;
  int mv = 0, rem = 0;
  bit mfill = 0, mdir = 0, mdone = 0, valid = 0;

  univ_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .rin(rin), .lin(lin),
    .d(d), .amt(amt), .q(q), .busy(busy), .done(done),
    .sout_r(sout_r), .sout_l(sout_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: register value as an integer mod 2^W; shifts are *2 / /2
  always @(posedge clk) begin
    int nv, nrem, n;
    bit nfill, ndir, dn;
    nv = mv; nrem = rem; nfill = mfill; ndir = mdir; dn = 0;
    if (clr) begin
      nv = 0; nrem = 0;
    end else if (rem > 0) begin
      nv = mdir ? mv / 2 + int'(mfill) * HALF : (mv * 2) % M + int'(mfill);
      nrem = rem - 1;
      dn = (nrem == 0);
    end else if (en) begin
      case (mode)
        3'd1: nv = (mv * 2) % M + int'(rin);
        3'd2: nv = mv / 2 + int'(lin) * HALF;
        3'd3: nv = int'(d);
        3'd4: nv = (mv * 2) % M + mv / HALF;
        3'd5: nv = mv / 2 + (mv % 2) * HALF;
        3'd6, 3'd7: begin
          n = int'(amt) > W ? W : int'(amt);
          nrem = n;
          ndir = mode[0];
          nfill = mode[0] ? lin : rin;
          dn = (n == 0);
        end
        default: ;
      endcase
    end
    mv <= nv; rem <= nrem; mfill <= nfill; mdir <= ndir; mdone <= dn;
    if (clr) valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("model_q", 64'(q), 64'(mv));
      chk("model_busy", 64'(busy), 64'(rem > 0));
      chk("model_done", 64'(done), 64'(mdone));
      chk("model_sout_r", 64'(sout_r), 64'(mv / HALF));
      chk("model_sout_l", 64'(sout_l), 64'(mv % 2));
    end
  end

  task automatic step(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                      input logic [AW-1:0] a, input logic r, input logic l);
    en = e; mode = m; d = dd; amt = a; rin = r; lin = l;
    @(negedge clk);
  endtask

  task automatic rnd_step();
    step(1'($urandom), 3'($urandom), W'($urandom), AW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    logic [W-1:0] exp_l [3];
    exp_l[0] = 8'h7F; exp_l[1] = 8'h3F; exp_l[2] = 8'h1F;
    clr = 1'b1; en = 1'b0; mode = 3'd0; d = '0; amt = '0; rin = 1'b0; lin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    step(1, 3'd3, 8'hA5, 0, 0, 0);
    chk("load_a5", 64'(q), 64'hA5);
    clr = 1'b1;
    step(0, 3'd3, 8'h00, 0, 0, 0);
    chk("clr_q", 64'(q), 64'h00);
    chk("clr_busy", 64'(busy), 64'h0);
    chk("clr_done", 64'(done), 64'h0);
    chk("clr_sout_l", 64'(sout_l), 64'h0);
    chk("clr_sout_r", 64'(sout_r), 64'h0);
    clr = 1'b0;
    step(1, 3'd3, 8'h96, 0, 0, 0);
    chk("load_96", 64'(q), 64'h96);
    step(1, 3'd1, 8'h00, 0, 1, 0);
    chk("shr_rin1", 64'(q), 64'h2D);
    step(1, 3'd2, 8'h00, 0, 0, 1);
    chk("shl_lin1", 64'(q), 64'h96);
    step(1, 3'd3, 8'h81, 0, 0, 0);
    step(1, 3'd4, 8'h00, 0, 0, 0);
    chk("rotr_81", 64'(q), 64'h03);
    step(1, 3'd3, 8'h81, 0, 0, 0);
    step(1, 3'd5, 8'h00, 0, 1, 1);
    chk("rotl_81", 64'(q), 64'hC0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'($urandom), W'($urandom), 0, 1'($urandom), 1'($urandom));
      chk("en0_hold", 64'(q), 64'hC0);
    end
    step(1, 3'd3, 8'hFF, 0, 0, 0);
    step(1, 3'd7, 8'h00, 3, 1, 0);
    chk("mshl_launch_q", 64'(q), 64'hFF);
    chk("mshl_launch_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 3; i++) begin
      rnd_step();
      chk("mshl_q", 64'(q), 64'(exp_l[i]));
      chk("mshl_busy", 64'(busy), 64'(i < 2));
      chk("mshl_done", 64'(done), 64'(i == 2));
    end
    step(0, 3'd0, 8'h00, 0, 0, 0);
    chk("mshl_done_once", 64'(done), 64'h0);
    step(1, 3'd3, 8'hFF, 0, 0, 0);
    step(1, 3'd6, 8'h00, 12, 0, 1);
    chk("mshr_launch_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 8; i++) begin
      rnd_step();
      chk("mshr_busy", 64'(busy), 64'(i < 7));
    end
    chk("mshr_clamp_q", 64'(q), 64'h00);
    chk("mshr_done", 64'(done), 64'h1);
    step(1, 3'd3, 8'h5A, 0, 0, 0);
    step(1, 3'd6, 8'h00, 0, 1, 1);
    chk("amt0_busy", 64'(busy), 64'h0);
    chk("amt0_done", 64'(done), 64'h1);
    chk("amt0_q", 64'(q), 64'h5A);
    step(1, 3'd7, 8'h00, 0, 1, 1);
    chk("b2b_amt0_done", 64'(done), 64'h1);
    step(1, 3'd3, 8'hC3, 0, 0, 0);
    step(1, 3'd6, 8'h00, 5, 1, 0);
    rnd_step();
    rnd_step();
    chk("abort_pre_q", 64'(q), 64'h0F);
    clr = 1'b1;
    rnd_step();
    chk("abort_q", 64'(q), 64'h00);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    clr = 1'b0;
    step(1, 3'd3, 8'h3C, 0, 0, 0);
    chk("post_abort_load", 64'(q), 64'h3C);
    chk("post_abort_done", 64'(done), 64'h0);
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 63) == 0);
      rnd_step();
    end
    clr = 1'b0;
    step(0, 3'd0, 8'h00, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter AMT_W, default $clog2(WIDTH+1), meaning width of the multi-shift amount port.
REQ-003 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 CLR  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 EN  input  1  command strobe; MODE is acted on only when EN=1 and the block is idle.
REQ-006 MODE  input  3  operation select, encoding per REQ-012.
REQ-007 RIN  input  1  serial input for shift-right fill, entering at Q[0].
REQ-008 LIN  input  1  serial input for shift-left fill, entering at Q[WIDTH-1].
REQ-009 D  input  WIDTH  parallel load data.
REQ-010 AMT  input  AMT_W  multi-shift bit count, sampled at launch.
REQ-011 Q  output  WIDTH; BUSY  output  1; DONE  output  1; SOUT_R  output  1 (=Q[WIDTH-1]); SOUT_L  output  1 (=Q[0]).

Function
REQ-012 MODE encoding SHALL be: 000 hold; 001 shift right; 010 shift left; 011 parallel load; 100 rotate right; 101 rotate left; 110 multi-shift right; 111 multi-shift left.
REQ-013 Shift right SHALL mean toward the MSB: Q[0]<=RIN, Q[i]<=Q[i-1].
REQ-014 Shift left SHALL mean toward the LSB: Q[WIDTH-1]<=LIN, Q[i]<=Q[i+1].
REQ-015 Rotate right SHALL set Q[0]<=Q[WIDTH-1]. Rotate left SHALL set Q[WIDTH-1]<=Q[0]. Neither SHALL use RIN or LIN.
REQ-016 Modes 000-101 SHALL complete in one edge. When EN=0, Q SHALL hold.
REQ-017 The FSM SHALL have two states, IDLE and RUN. BUSY SHALL be 1 exactly when the state is RUN.
REQ-018 Launch SHALL occur on an IDLE edge with EN=1 and MODE=11x.
REQ-019 At launch, the counter SHALL load min(AMT, WIDTH), the fill bit SHALL latch (RIN for 110, LIN for 111), the direction SHALL latch, and Q SHALL NOT change.
REQ-020 If the clamped count is 0 at launch, the state SHALL stay IDLE and DONE SHALL be 1 for the next cycle.
REQ-021 If the clamped count is nonzero at launch, the state SHALL go to RUN.
REQ-022 Each RUN edge SHALL perform one shift in the latched direction with the latched fill bit, and SHALL decrement the counter.
REQ-023 The RUN edge on which the counter goes from 1 to 0 SHALL return the state to IDLE and SHALL set DONE=1 for exactly one cycle.
REQ-024 A count of n>0 SHALL give BUSY high for n cycles, DONE on the cycle after BUSY falls, and the final Q visible together with DONE.
REQ-025 During RUN, EN, MODE, AMT, D, RIN and LIN SHALL be ignored. The shift SHALL use only the latched values.
REQ-026 An EN command on the cycle DONE=1 SHALL be accepted normally, allowing back-to-back launches.
REQ-027 DONE SHALL be 0 on every cycle other than those defined in REQ-020 and REQ-023.
REQ-028 SOUT_R and SOUT_L SHALL be combinational from Q, with no added latency.

Reset
REQ-029 CLR=1 at an edge SHALL set Q=0, BUSY=0, DONE=0, state IDLE, and counter 0, with priority over EN and over the FSM.
REQ-030 CLR asserted during RUN SHALL abort the shift with no DONE pulse. The block SHALL accept a command on the first edge after CLR deasserts.
REQ-031 Before the first CLR, outputs are unspecified. The bench SHALL apply CLR for at least one edge first.

Verification (WIDTH=8)
REQ-032 Q=0xA5, CLR=1 for one edge -> Q=0x00, BUSY=0, DONE=0, SOUT_L=0, SOUT_R=0.
REQ-033 EN=1 MODE=011 D=0x96, then MODE=001 RIN=1 -> Q=0x96, then Q=0x2D; then MODE=010 LIN=1 -> Q=0x96.
REQ-034 Load 0x81, MODE=100 -> Q=0x03; reload 0x81, MODE=101 -> Q=0xC0; EN=0 for 3 edges -> Q stays 0xC0.
REQ-035 Load 0xFF, MODE=111 AMT=3 LIN=0, with MODE toggled randomly during BUSY -> BUSY high for 3 cycles, Q=0x7F,0x3F,0x1F, DONE pulse with Q=0x1F.
REQ-036 Load 0xFF, MODE=110 AMT=12 RIN=0 -> clamped to 8, BUSY for 8 cycles, final Q=0x00. Then AMT=0 -> no BUSY, DONE next cycle, Q unchanged.
REQ-037 Launch AMT=5, assert CLR after 2 shifts -> Q=0x00, BUSY=0, no DONE; a MODE=011 D=0x3C on the next edge loads 0x3C.
